// File: rtl/mux_rr_nx1_pkg.sv
// mux_rr_nx1_pkg: shared mode encoding for the round-robin mux
package mux_rr_nx1_pkg;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;
endpackage

// File: rtl/mux_rr_nx1_if.sv
// mux_rr_nx1_if: producer-side channels, control and registered consumer side of the mux
interface mux_rr_nx1_if #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int SW = $clog2(N)
) ();
  import mux_rr_nx1_pkg::*;
  mode_e mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_ch;
  logic out_valid;
  logic out_ready;
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    input mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_rr_nx1_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter starting its search at ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [SW:0] sum;
  // rotate so that bit 0 of rot is the channel at ptr
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  always_comb begin
    grant = '0;
    grant_idx = '0;
    any = 1'b0;
    sum = '0;
    for (int i = N - 1; i >= 0; i--)
      if (en && rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (SW+1)'(i);
      end
    if (any) begin
      grant_idx = sum >= (SW+1)'(N) ? SW'(sum - (SW+1)'(N)) : SW'(sum);
      grant[grant_idx] = 1'b1;
    end
  end
endmodule

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-to-1 valid/ready mux, fixed-select or round-robin, registered output
module mux_rr_nx1
  import mux_rr_nx1_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  parameter int SW = $clog2(N)
) (
  input logic clk,
  input logic rst,
  mux_rr_nx1_if.slave bus
);
  logic load_en, any, rr;
  logic [SW-1:0] ptr, arb_ptr, grant_idx;
  logic [N-1:0] req, grant;
  assign load_en = !bus.out_valid || bus.out_ready;
  assign rr = bus.mode == MODE_RR;
  // fixed mode reuses the arbiter with a lone request at sel; sel >= N shifts it out entirely
  assign req = rr ? bus.in_valid : bus.in_valid & ({{(N-1){1'b0}}, 1'b1} << bus.sel);
  assign arb_ptr = rr ? ptr : bus.sel;
  assign bus.in_ready = grant;
  rr_arbiter #(.N(N)) u_arb (
    .req(req),
    .ptr(arb_ptr),
    .en(load_en),
    .grant(grant),
    .grant_idx(grant_idx),
    .any(any)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch <= '0;
      ptr <= '0;
    end else if (load_en) begin
      bus.out_valid <= any;
      if (any) begin
        bus.out_data <= bus.in_data[grant_idx*W +: W];
        bus.out_ch <= grant_idx;
        if (rr) ptr <= grant_idx == SW'(N - 1) ? '0 : grant_idx + 1'b1;
      end
    end
endmodule
